// File: rtl/service_dispatcher.sv
// Purpose: calls waiting ticket numbers to free service counters A-E and tracks which counters are busy.
// Latency: a dispatch happens on the edge after the ticket is counted; call_valid then stays high for ANNOUNCE_CYCLES.
// Backpressure: tickets wait in a count until a counter frees up; arrivals at MAX_NUMBER waiting are dropped (sticky overflow).
//
// Ports:
//   clk, rst (synchronous, active-low)
//   ticket_issued    one-cycle pulse per new ticket
//   counter_done[4:0] per-counter "customer finished" pulse (bit0 = A)
//   counter_busy[4:0] per-counter serving flag
//   call_valid, counter_call (1..5, 0 when idle), number_service
//   A..E_serviceNumber  last number called to each counter
//   waiting          tickets issued but not yet called
//   overflow         sticky drop indicator
// Optional feature: define DISPATCH_ROUND_ROBIN_EN for round-robin counter
// selection; otherwise the lowest-indexed idle counter wins.
module service_dispatcher #(
    parameter int NUM_WIDTH       = 6,
    parameter int MAX_NUMBER      = 60,
    parameter int ANNOUNCE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ticket_issued,
    input  logic [4:0]           counter_done,
    output logic [4:0]           counter_busy,
    output logic                 call_valid,
    output logic [2:0]           counter_call,
    output logic [NUM_WIDTH-1:0] number_service,
    output logic [NUM_WIDTH-1:0] A_serviceNumber,
    output logic [NUM_WIDTH-1:0] B_serviceNumber,
    output logic [NUM_WIDTH-1:0] C_serviceNumber,
    output logic [NUM_WIDTH-1:0] D_serviceNumber,
    output logic [NUM_WIDTH-1:0] E_serviceNumber,
    output logic [NUM_WIDTH:0]   waiting,
    output logic                 overflow
);

    typedef enum logic {
        ST_IDLE,
        ST_ANNOUNCE
    } state_t;

    localparam int CNT_W = (ANNOUNCE_CYCLES > 1) ? $clog2(ANNOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]     ANN_LAST = CNT_W'(ANNOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]     ANN_ONE  = CNT_W'(1);
    localparam logic [NUM_WIDTH-1:0] NUM_MAX  = NUM_WIDTH'(MAX_NUMBER);
    localparam logic [NUM_WIDTH-1:0] NUM_ONE  = NUM_WIDTH'(1);
    localparam logic [NUM_WIDTH:0]   WAIT_MAX = (NUM_WIDTH + 1)'(MAX_NUMBER);
    localparam logic [NUM_WIDTH:0]   WAIT_ONE = (NUM_WIDTH + 1)'(1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     ann_cnt_q, ann_cnt_d;
    logic [4:0]           busy_q, busy_d;
    logic                 call_valid_q, call_valid_d;
    logic [2:0]           counter_call_q, counter_call_d;
    logic [NUM_WIDTH-1:0] number_service_q, number_service_d;
    logic [NUM_WIDTH-1:0] next_num_q, next_num_d;
    logic [NUM_WIDTH-1:0] svc_num_q [5];
    logic [NUM_WIDTH-1:0] svc_num_d [5];
    logic [NUM_WIDTH:0]   waiting_q, waiting_d;
    logic                 overflow_q, overflow_d;

    logic                 sel_found;
    logic [2:0]           sel_idx;
    logic                 dispatch;
    logic                 ticket_accept;

`ifdef DISPATCH_ROUND_ROBIN_EN
    // Index of the first counter to consider on the next dispatch.
    logic [2:0] rr_ptr_q, rr_ptr_d;
    logic [2:0] rr_cand;
`endif

    // Counter selection works on the registered busy flags, so a done pulse
    // arriving on this edge only makes its counter eligible one cycle later.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = 3'd0;
`ifdef DISPATCH_ROUND_ROBIN_EN
        rr_cand   = 3'd0;
        for (int j = 0; j < 5; j++) begin
            rr_cand = 3'((int'(rr_ptr_q) + j) % 5);
            if (!sel_found && !busy_q[rr_cand]) begin
                sel_found = 1'b1;
                sel_idx   = rr_cand;
            end
        end
`else
        for (int i = 0; i < 5; i++) begin
            if (!sel_found && !busy_q[i]) begin
                sel_found = 1'b1;
                sel_idx   = 3'(i);
            end
        end
`endif
    end

    assign dispatch      = (state_q == ST_IDLE) && (waiting_q != '0) && sel_found;
    // Full check uses the pre-edge count, even if a dispatch frees a slot on the same edge.
    assign ticket_accept = ticket_issued && (waiting_q != WAIT_MAX);

    always_comb begin
        state_d          = state_q;
        ann_cnt_d        = ann_cnt_q;
        call_valid_d     = call_valid_q;
        counter_call_d   = counter_call_q;
        number_service_d = number_service_q;
        next_num_d       = next_num_q;
        svc_num_d        = svc_num_q;
        waiting_d        = waiting_q;
        overflow_d       = overflow_q;
        // Done pulses on idle counters are harmless: the bit is already clear.
        busy_d           = busy_q & ~counter_done;
`ifdef DISPATCH_ROUND_ROBIN_EN
        rr_ptr_d         = rr_ptr_q;
`endif

        if (ticket_issued && !ticket_accept) begin
            overflow_d = 1'b1;
        end

        if (ticket_accept && !dispatch) begin
            waiting_d = waiting_q + WAIT_ONE;
        end else if (!ticket_accept && dispatch) begin
            waiting_d = waiting_q - WAIT_ONE;
        end

        case (state_q)
            ST_IDLE: begin
                if (dispatch) begin
                    state_d            = ST_ANNOUNCE;
                    ann_cnt_d          = '0;
                    // Set after the done-clear so a same-edge done cannot free k.
                    busy_d[sel_idx]    = 1'b1;
                    svc_num_d[sel_idx] = next_num_q;
                    number_service_d   = next_num_q;
                    next_num_d         = (next_num_q == NUM_MAX) ? NUM_ONE : next_num_q + NUM_ONE;
                    call_valid_d       = 1'b1;
                    counter_call_d     = sel_idx + 3'd1;
`ifdef DISPATCH_ROUND_ROBIN_EN
                    rr_ptr_d           = (sel_idx == 3'd4) ? 3'd0 : sel_idx + 3'd1;
`endif
                end
            end
            ST_ANNOUNCE: begin
                if (ann_cnt_q == ANN_LAST) begin
                    state_d        = ST_IDLE;
                    call_valid_d   = 1'b0;
                    counter_call_d = 3'd0;
                end else begin
                    ann_cnt_d = ann_cnt_q + ANN_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q          <= ST_IDLE;
            ann_cnt_q        <= '0;
            busy_q           <= '0;
            call_valid_q     <= 1'b0;
            counter_call_q   <= 3'd0;
            number_service_q <= '0;
            next_num_q       <= NUM_ONE;
            svc_num_q        <= '{default: '0};
            waiting_q        <= '0;
            overflow_q       <= 1'b0;
`ifdef DISPATCH_ROUND_ROBIN_EN
            rr_ptr_q         <= 3'd0;
`endif
        end else begin
            state_q          <= state_d;
            ann_cnt_q        <= ann_cnt_d;
            busy_q           <= busy_d;
            call_valid_q     <= call_valid_d;
            counter_call_q   <= counter_call_d;
            number_service_q <= number_service_d;
            next_num_q       <= next_num_d;
            svc_num_q        <= svc_num_d;
            waiting_q        <= waiting_d;
            overflow_q       <= overflow_d;
`ifdef DISPATCH_ROUND_ROBIN_EN
            rr_ptr_q         <= rr_ptr_d;
`endif
        end
    end

    assign counter_busy    = busy_q;
    assign call_valid      = call_valid_q;
    assign counter_call    = counter_call_q;
    assign number_service  = number_service_q;
    assign A_serviceNumber = svc_num_q[0];
    assign B_serviceNumber = svc_num_q[1];
    assign C_serviceNumber = svc_num_q[2];
    assign D_serviceNumber = svc_num_q[3];
    assign E_serviceNumber = svc_num_q[4];
    assign waiting         = waiting_q;
    assign overflow        = overflow_q;

endmodule

// File: doc/service_dispatcher.md
# service_dispatcher

Counter-side dispatcher of the queue response system. It counts issued tickets, tracks which of the five service counters (A–E) are free, and calls the next waiting ticket number to a free counter. It sits between the ticket dispenser and the counter displays/announcer. It is the serving end of the ticket stream that `response_system_top` issues.

## Interface

Parameters:
- `NUM_WIDTH`, 6: ticket number width.
- `MAX_NUMBER`, 60: highest ticket number. Numbers run 1..MAX_NUMBER, then wrap to 1. Must be ≤ 2^NUM_WIDTH−1.
- `ANNOUNCE_CYCLES`, 2: number of cycles `call_valid` stays high per call. Must be ≥ 1.

Ports:
- `clk`  in  1: system clock. All logic is rising-edge.
- `rst`  in  1: synchronous, active-low reset, sampled on `clk` rising edge.
- `ticket_issued`  in  1: one-cycle pulse. One new ticket has been issued by the dispenser.
- `counter_done`  in  5: bit i pulses when counter i has finished its customer. Bit 0 is A … bit 4 is E.
- `counter_busy`  out  5: bit i high while counter i is serving.
- `call_valid`  out  1: high while a call is being announced.
- `counter_call`  out  3: counter being called, 1..5 for A..E. 0 when no call is active.
- `number_service`  out  NUM_WIDTH: ticket number being called. Holds its last value when idle.
- `A_serviceNumber` … `E_serviceNumber`  out  NUM_WIDTH each: last number called to that counter. 0 if the counter has never been called.
- `waiting`  out  NUM_WIDTH+1: tickets issued but not yet called.
- `overflow`  out  1: sticky. Set when a ticket arrives while `waiting` == MAX_NUMBER.

## Operation

- Reset (`rst`=0 at an edge):
  - All outputs go to 0.
  - Next-number register goes to 1.
  - FSM goes to IDLE.
  - Round-robin pointer goes to A.
- `ticket_issued`:
  - `waiting` increments.
  - If `waiting` == MAX_NUMBER, the ticket is dropped and `overflow` is set. `overflow` clears only on reset.
- `counter_done[i]`:
  - Clears `counter_busy[i]`.
  - Ignored if counter i is already idle.
- FSM, two states:
  - IDLE → ANNOUNCE when `waiting` > 0 and at least one counter is idle, with idleness taken from the registered `counter_busy`. On that edge:
    - Select counter k.
    - Set `counter_busy[k]`.
    - Load `number_service` and `k_serviceNumber` with the next number.
    - Advance the next number (MAX_NUMBER → 1).
    - Decrement `waiting`.
    - Assert `call_valid` and set `counter_call` = k+1.
  - ANNOUNCE → IDLE after `call_valid` has been high for ANNOUNCE_CYCLES cycles. On that edge, `call_valid` and `counter_call` return to 0.
  - No dispatch happens while in ANNOUNCE.
- Counter selection:
  - Round-robin starting at the counter after the last one called (see Configuration).
  - The pointer advances only on a dispatch.
- Simultaneous events:
  - `ticket_issued` on the same edge as a dispatch: `waiting` is unchanged (+1 −1).
  - `counter_done[i]` on the same edge as an IDLE evaluation: counter i is not selectable that cycle, because the old busy value is used. It becomes selectable on the next cycle.
  - `counter_done[k]` on the same edge k is dispatched: the dispatch wins and `counter_busy[k]` stays 1.
- Reset mid-ANNOUNCE: the call is aborted and all state is cleared. Tickets already counted in `waiting` are lost.

## Timing

- Latency: `ticket_issued` at edge t, with the queue empty, FSM in IDLE, and a counter free:
  - `waiting` = 1 after t.
  - `call_valid` = 1 after t+1.
- Call spacing: back-to-back calls are at least ANNOUNCE_CYCLES+1 cycles apart, start to start.
- Counter outputs: `counter_busy` and `*_serviceNumber` update on the dispatch edge, the same edge `call_valid` rises.
- `counter_call` and `number_service` are stable for the entire `call_valid` window.

## Configuration

- `DISPATCH_ROUND_ROBIN_EN` defined:
  - Search starts at the counter after the last one called, wrapping E → A.
- `DISPATCH_ROUND_ROBIN_EN` undefined:
  - Fixed priority: the lowest-indexed idle counter (A highest) is selected.
  - The pointer logic is not compiled.

## Test plan

- **Reset:** hold `rst`=0 for 2 cycles → all outputs 0. After release, first dispatch calls number 1.
- **Single ticket:** one `ticket_issued` pulse →
  - one cycle later `call_valid`=1, `counter_call`=1, `number_service`=1, `A_serviceNumber`=1, `counter_busy`=5'b00001;
  - `call_valid` low after 2 cycles.
- **Seven tickets back-to-back, no done:**
  - Round-robin: calls go A..E with numbers 1..5, each 3 cycles apart. `waiting` then stays at 2 and `counter_busy`=5'b11111.
  - Pulse `counter_done[2]` → number 6 is called to C (`counter_call`=3).
- **Simultaneous events:**
  - `ticket_issued` on the dispatch edge → `waiting` unchanged.
  - `counter_done[k]` on the IDLE edge → k is not selected that cycle; it is selected next cycle if it is the only free counter.
- **Wrap and overflow:**
  - After number 60 is called, the next call is number 1.
  - 61 pulses with all counters busy → `waiting`=60 and `overflow`=1.
- **Macro off:** with counters A and C free, the call goes to A. With the macro on and the pointer past A, the call goes to C.
